// File: rtl/axi2mat_burst_sched_if.sv
// Job-control, row-count FIFO and read-command signals of the burst scheduler.
// The master modport is the scheduler's view; slave is the surrounding system's view.
interface axi2mat_burst_sched_if #(
    parameter int ADDR_W = 64
);
    logic              ap_start;
    logic              ap_continue;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       stride;
    logic [10:0]       rows;
    logic [31:0]       row_bytes;
    logic [10:0]       rows_c_din;
    logic              rows_c_full_n;
    logic              rows_c_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_len;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmp_valid;

    modport master (
        input  ap_start, ap_continue, base_addr, stride, rows, row_bytes,
               rows_c_full_n, cmd_ready, cmp_valid,
        output ap_ready, ap_done, ap_idle, rows_c_din, rows_c_write,
               cmd_addr, cmd_len, cmd_valid
    );

    modport slave (
        output ap_start, ap_continue, base_addr, stride, rows, row_bytes,
               rows_c_full_n, cmd_ready, cmp_valid,
        input  ap_ready, ap_done, ap_idle, rows_c_din, rows_c_write,
               cmd_addr, cmd_len, cmd_valid
    );
endinterface

// File: rtl/axi2mat_burst_sched.sv
// Frame read scheduler: forwards the row count downstream, then issues one
// contiguous or per-row strided read command stream with an outstanding limit.
module axi2mat_burst_sched #(
    parameter int ADDR_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic ap_clk,
    input  logic ap_rst,
    axi2mat_burst_sched_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FWD, S_ISSUE, S_DRAIN, S_DONE} state_e;

    localparam logic [3:0]  MAX_Q  = 4'(MAX_OUT);
    localparam logic [31:0] CONTIG = 32'hFFFF_FFFF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       stride_q, stride_d;
    logic [31:0]       len_q, len_d;
    logic [10:0]       rows_q, rows_d;
    logic [10:0]       left_q, left_d;
    logic [3:0]        out_q, out_d;

    logic can_issue, xfer, fifo_wr, cmp_ok;

    assign can_issue = (state_q == S_ISSUE) && (out_q != MAX_Q);
    assign xfer      = can_issue && bus.cmd_ready;
    assign fifo_wr   = (state_q == S_FWD) && bus.rows_c_full_n;
    // Completions with nothing outstanding (e.g. stragglers from before a reset) are dropped.
    assign cmp_ok    = bus.cmp_valid && (out_q != 4'd0);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ap_start)              state_d = S_FWD;
            S_FWD:   if (fifo_wr)                   state_d = (rows_q != 11'd0) ? S_ISSUE : S_DRAIN;
            S_ISSUE: if (xfer && left_q == 11'd1)   state_d = S_DRAIN;
            S_DRAIN: if (out_q == 4'd0)             state_d = S_DONE;
            S_DONE:  if (bus.ap_continue)           state_d = S_IDLE;
            default:                                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ap_idle      = (state_q == S_IDLE);
        bus.ap_ready     = fifo_wr;
        bus.ap_done      = (state_q == S_DONE);
        bus.rows_c_write = fifo_wr;
        bus.rows_c_din   = rows_q;
        bus.cmd_valid    = can_issue;
        bus.cmd_addr     = addr_q;
        bus.cmd_len      = len_q;
    end

    // Strided addresses come from a running accumulator; only the one-off
    // contiguous length uses a multiply, and it is computed at capture time.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        rows_d   = rows_q;
        left_d   = left_q;
        if (state_q == S_IDLE && bus.ap_start) begin
            addr_d   = bus.base_addr;
            stride_d = bus.stride;
            rows_d   = bus.rows;
            if (bus.stride == CONTIG) begin
                len_d  = bus.row_bytes * {21'd0, bus.rows};
                left_d = 11'd1;
            end else begin
                len_d  = bus.row_bytes;
                left_d = bus.rows;
            end
        end else if (xfer) begin
            addr_d = addr_q + ADDR_W'(stride_q);
            left_d = left_q - 11'd1;
        end
        case ({xfer, cmp_ok})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            rows_q   <= '0;
            left_q   <= '0;
            out_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            rows_q   <= rows_d;
            left_q   <= left_d;
            out_q    <= out_d;
        end
    end
endmodule

// File: tb/tb_axi2mat_burst_sched.sv
// Directed bench for axi2mat_burst_sched: strided, contiguous, zero-row,
// FIFO backpressure, outstanding limit and mid-job reset.
module tb_axi2mat_burst_sched;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    axi2mat_burst_sched_if #(.ADDR_W(64)) bus ();

    axi2mat_burst_sched #(.ADDR_W(64), .MAX_OUT(4)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.master)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_xfer  = 0;
    int          n_wr    = 0;
    logic        auto_cmp = 1'b0;
    logic [63:0] log_addr [16];
    logic [31:0] log_len  [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: log the transfer/FIFO write happening at this edge, then
    // optionally answer each transfer with a completion in the following cycle.
    task automatic tick();
        logic x;
        #1;
        x = bus.cmd_valid && bus.cmd_ready;
        if (x && n_xfer < 16) begin
            log_addr[n_xfer] = bus.cmd_addr;
            log_len[n_xfer]  = bus.cmd_len;
        end
        if (x) n_xfer++;
        if (bus.rows_c_write) n_wr++;
        @(posedge ap_clk);
        #1;
        bus.cmp_valid = auto_cmp && x;
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] strd,
                             input logic [10:0] nrows, input logic [31:0] rb);
        bus.base_addr = base;
        bus.stride    = strd;
        bus.rows      = nrows;
        bus.row_bytes = rb;
        bus.ap_start  = 1'b1;
        n_xfer = 0;
        n_wr   = 0;
        tick();
        bus.ap_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc = 0;
        while (!bus.ap_done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, 64'(bus.ap_done), 64'd1);
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic finish_job(input string tag);
        bus.ap_continue = 1'b1;
        tick();
        bus.ap_continue = 1'b0;
        chk({tag, "_idle"}, 64'(bus.ap_idle), 64'd1);
    endtask

    initial begin
        logic seen;
        bus.ap_start      = 1'b0;
        bus.ap_continue   = 1'b0;
        bus.base_addr     = '0;
        bus.stride        = '0;
        bus.rows          = '0;
        bus.row_bytes     = '0;
        bus.rows_c_full_n = 1'b1;
        bus.cmd_ready     = 1'b1;
        bus.cmp_valid     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_idle",  64'(bus.ap_idle), 64'd1);
        chk("rst_done",  64'(bus.ap_done), 64'd0);
        chk("rst_ready", 64'(bus.ap_ready), 64'd0);
        chk("rst_cmdv",  64'(bus.cmd_valid), 64'd0);
        chk("rst_din",   64'(bus.rows_c_din), 64'd0);
        ap_rst = 1'b0;
        tick();

        // Strided frame, immediate completions
        auto_cmp = 1'b1;
        start_job(64'h1000, 32'h800, 11'd3, 32'h780);
        chk("str_ready", 64'(bus.ap_ready), 64'd1);
        chk("str_din",   64'(bus.rows_c_din), 64'd3);
        tick();
        chk("str_cmdv_lat", 64'(bus.cmd_valid), 64'd1);
        wait_done("str", 5);
        chk("str_nx",    64'(n_xfer), 64'd3);
        chk("str_a0",    log_addr[0], 64'h1000);
        chk("str_a1",    log_addr[1], 64'h1800);
        chk("str_a2",    log_addr[2], 64'h2000);
        chk("str_l2",    64'(log_len[2]), 64'h780);
        finish_job("str");

        // Contiguous frame
        start_job(64'hFFFF_0000_1234_5000, 32'hFFFF_FFFF, 11'd4, 32'h100);
        chk("cont_din", 64'(bus.rows_c_din), 64'd4);
        tick();
        wait_done("cont", 3);
        chk("cont_nx",  64'(n_xfer), 64'd1);
        chk("cont_a0",  log_addr[0], 64'hFFFF_0000_1234_5000);
        chk("cont_l0",  64'(log_len[0]), 64'h400);
        chk("cont_nwr", 64'(n_wr), 64'd1);
        finish_job("cont");

        // Zero rows: FIFO write of 0, done two cycles later
        start_job(64'h0, 32'h10, 11'd0, 32'h10);
        chk("zero_wr",  64'(bus.rows_c_write), 64'd1);
        chk("zero_din", 64'(bus.rows_c_din), 64'd0);
        tick();
        chk("zero_done_early", 64'(bus.ap_done), 64'd0);
        tick();
        chk("zero_done", 64'(bus.ap_done), 64'd1);
        chk("zero_nx",   64'(n_xfer), 64'd0);
        finish_job("zero");

        // Downstream FIFO full for 5 cycles, then a stalled command channel
        bus.rows_c_full_n = 1'b0;
        start_job(64'h10000, 32'h200, 11'd2, 32'h80);
        seen = 1'b0;
        repeat (5) begin
            #1;
            seen = seen | bus.ap_ready | bus.cmd_valid | bus.rows_c_write;
            tick();
        end
        chk("full_quiet", 64'(seen), 64'd0);
        bus.rows_c_full_n = 1'b1;
        #1;
        chk("full_ready", 64'(bus.ap_ready), 64'd1);
        bus.cmd_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_v",  64'(bus.cmd_valid), 64'd1);
        chk("stall_a",  bus.cmd_addr, 64'h10000);
        chk("stall_l",  64'(bus.cmd_len), 64'h80);
        chk("stall_nx", 64'(n_xfer), 64'd0);
        bus.cmd_ready = 1'b1;
        wait_done("full", 4);
        chk("full_nx", 64'(n_xfer), 64'd2);
        chk("full_a1", log_addr[1], 64'h10200);
        finish_job("full");

        // Outstanding limit with no completions
        auto_cmp = 1'b0;
        start_job(64'h0, 32'h40, 11'd8, 32'h40);
        tick();
        repeat (4) tick();
        chk("bp_nx4", 64'(n_xfer), 64'd4);
        chk("bp_v0",  64'(bus.cmd_valid), 64'd0);
        tick();
        tick();
        chk("bp_nx4_hold", 64'(n_xfer), 64'd4);
        bus.cmp_valid = 1'b1;
        tick();
        chk("bp_v1", 64'(bus.cmd_valid), 64'd1);
        tick();
        chk("bp_nx5", 64'(n_xfer), 64'd5);
        chk("bp_a4",  log_addr[4], 64'h100);
        chk("bp_v0b", 64'(bus.cmd_valid), 64'd0);
        ap_rst = 1'b1;
        #1;
        chk("bp_rst_idle", 64'(bus.ap_idle), 64'd1);
        tick();
        ap_rst = 1'b0;
        tick();

        // Reset after 2 of 5 strided commands, then a clean restart
        auto_cmp = 1'b1;
        start_job(64'h4000, 32'h100, 11'd5, 32'h20);
        tick();
        tick();
        tick();
        chk("mid_nx2", 64'(n_xfer), 64'd2);
        ap_rst = 1'b1;
        #1;
        chk("mid_idle",  64'(bus.ap_idle), 64'd1);
        chk("mid_cmdv",  64'(bus.cmd_valid), 64'd0);
        chk("mid_addr",  bus.cmd_addr, 64'h0);
        chk("mid_len",   64'(bus.cmd_len), 64'h0);
        chk("mid_din",   64'(bus.rows_c_din), 64'd0);
        chk("mid_wr",    64'(bus.rows_c_write), 64'd0);
        chk("mid_done",  64'(bus.ap_done), 64'd0);
        tick();
        ap_rst = 1'b0;
        bus.cmp_valid = 1'b1;
        tick();
        start_job(64'h4000, 32'h100, 11'd5, 32'h20);
        tick();
        chk("re_a_first", bus.cmd_addr, 64'h4000);
        wait_done("re", 7);
        chk("re_nx", 64'(n_xfer), 64'd5);
        chk("re_a0", log_addr[0], 64'h4000);
        chk("re_a4", log_addr[4], 64'h4400);
        chk("re_l4", 64'(log_len[4]), 64'h20);
        finish_job("re");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi2mat_burst_sched.md
AXI2MAT_BURST_SCHED -- requirements
Module: axi2mat_burst_sched

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width of cmd_addr and base_addr.
REQ-002 Parameter MAX_OUT, default 4, maximum outstanding read commands (range 1..15).
REQ-003 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 ap_rst  in  1  reset, asynchronous and active-high.
REQ-005 ap_start  in  1  job request; ap_continue  in  1  acknowledges ap_done.
REQ-006 ap_ready  out  1  job parameters captured; ap_done  out  1  job finished; ap_idle  out  1  block idle.
REQ-007 base_addr  in  ADDR_W  frame start byte address; stride  in  32  row pitch in bytes, 0xFFFFFFFF = contiguous frame.
REQ-008 rows  in  11  row count; row_bytes  in  32  bytes per row.
REQ-009 rows_c_din  out  11  row count forwarded downstream; rows_c_full_n  in  1  FIFO not full; rows_c_write  out  1  FIFO write strobe.
REQ-010 cmd_addr  out  ADDR_W, cmd_len  out  32 (bytes), cmd_valid  out  1, cmd_ready  in  1: read-command channel.
REQ-011 cmp_valid  in  1  one-cycle pulse per completed command from the datapath.

Function
REQ-012 FSM states: IDLE, FWD, ISSUE, DRAIN, DONE.
REQ-013 IDLE: ap_idle=1; on ap_start=1, capture base_addr, stride, rows, row_bytes; go to FWD next cycle.
REQ-014 FWD: rows_c_din = captured rows; rows_c_write = rows_c_full_n; on write, ap_ready=1 for that cycle only, go to ISSUE (rows != 0) or DRAIN (rows == 0).
REQ-015 Contiguous mode (stride == 0xFFFFFFFF): exactly one command, addr = base_addr, len = rows*row_bytes truncated to 32 bits.
REQ-016 Strided mode: exactly rows commands, command i addr = base_addr + i*stride (stride zero-extended, sum modulo 2^ADDR_W), len = row_bytes.
REQ-017 Commands issue in ascending i; a command transfers when cmd_valid & cmd_ready; cmd_addr/cmd_len stable while cmd_valid=1 and cmd_ready=0.
REQ-018 cmd_valid deasserted while outstanding count == MAX_OUT; back-to-back transfers at one per cycle otherwise.
REQ-019 Outstanding count: +1 on transfer, -1 on cmp_valid; both in same cycle leaves it unchanged.
REQ-020 After last transfer go to DRAIN; DRAIN exits to DONE when outstanding == 0 (including same-cycle cmp_valid bringing it to 0, seen next cycle).
REQ-021 DONE: ap_done=1 held until ap_continue=1, then IDLE next cycle; ap_continue outside DONE ignored.
REQ-022 ap_start while not IDLE ignored; cmp_valid with outstanding == 0 ignored (count saturates at 0).
REQ-023 Address computed by running accumulator (add stride per transfer), no multiplier in the strided path.
REQ-024 Latency: first cmd_valid two cycles after ap_start sampled in IDLE when rows_c_full_n=1.

Reset
REQ-025 ap_rst asserted at any time, including mid-job, forces IDLE immediately; outstanding count, row counter, captured registers = 0.
REQ-026 Reset values: ap_idle=1; ap_done, ap_ready, rows_c_write, cmd_valid = 0; cmd_addr, cmd_len, rows_c_din = 0.
REQ-027 Commands in flight at reset are abandoned; late cmp_valid pulses after reset are ignored per REQ-022.

Verification
REQ-028 Strided: base=0x1000, stride=0x800, rows=3, row_bytes=0x780, cmd_ready=1, immediate cmp -> cmds (0x1000,0x780),(0x1800,0x780),(0x2000,0x780); ap_done after last cmp.
REQ-029 Contiguous: stride=0xFFFFFFFF, rows=4, row_bytes=0x100 -> single cmd (base, 0x400); rows_c_din=4 written once.
REQ-030 Backpressure: MAX_OUT=4, rows=8, no cmp -> exactly 4 transfers then cmd_valid=0; one cmp -> one more transfer.
REQ-031 rows=0 -> FIFO write of 0, no commands, ap_done two cycles after FWD write.
REQ-032 rows_c_full_n=0 for 5 cycles -> no ap_ready, no cmd_valid until it rises; then normal job.
REQ-033 ap_rst asserted after 2 of 5 strided commands -> all outputs at reset values same cycle; new job starts clean from command 0.
